// File: rtl/serial_word_tx_if.sv
// -----------------------------------------------------------------------------
// serial_word_tx_if
//   Bundles the word-input handshake and the serial output of serial_word_tx.
//
//   in_data    producer -> tx   WIDTH-bit word, sampled only on an accept edge
//   in_valid   producer -> tx   a word is being offered
//   in_ready   tx -> producer   tx can take a word this cycle
//   ser_out    tx -> consumer   serial data bit (0 whenever ser_valid is low)
//   ser_valid  tx -> consumer   ser_out carries a frame bit this cycle
//   frame_done tx -> consumer   one-cycle pulse alongside the last bit of a frame
//   busy       tx -> consumer   tx is shifting a frame or sitting in the gap
//
//   Modports:
//     master - the side that offers words and observes the serial stream
//     slave  - the serializer itself
// -----------------------------------------------------------------------------
interface serial_word_tx_if #(
  parameter int WIDTH = 6
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_done;
  logic             busy;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  ser_out,
    input  ser_valid,
    input  frame_done,
    input  busy
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output ser_out,
    output ser_valid,
    output frame_done,
    output busy
  );

endinterface

// File: rtl/serial_word_tx.sv
// -----------------------------------------------------------------------------
// serial_word_tx
//   Parallel-in / serial-out framer feeding the serial data input of a
//   downstream D flip-flop shift register that shares this clock. One WIDTH-bit
//   word is taken per valid/ready handshake and sent one bit per clock, with a
//   bit qualifier (ser_valid) and an end-of-frame strobe (frame_done). After
//   WIDTH shift edges the downstream register holds the word, with the bit sent
//   first sitting in its last stage.
//
// Parameters
//   WIDTH       bits per word, 2..32
//   GAP_CYCLES  idle cycles after each frame, 0..255 (0 skips the gap state)
//   MSB_FIRST   1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//
// Ports
//   clk      rising-edge clock
//   clear_n  asynchronous active-low reset; aborts any frame in flight
//   bus      serial_word_tx_if.slave: in_data/in_valid/in_ready handshake and
//            ser_out/ser_valid/frame_done/busy outputs
//
// Timing, for a word accepted at edge k:
//   cycles k+1 .. k+WIDTH                 one frame bit per cycle, ser_valid=1
//   cycle  k+WIDTH                        frame_done=1 with the last bit
//   cycles k+WIDTH+1 .. k+WIDTH+GAP       gap, busy=1, ser_valid=0
//   edge   k+WIDTH+GAP_CYCLES+1           earliest next accept
//
// Every output is a flop, so nothing on the input side reaches an output
// without passing through a clock edge.
// -----------------------------------------------------------------------------
module serial_word_tx #(
  parameter int WIDTH      = 6,
  parameter int GAP_CYCLES = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic            clk,
  input  logic            clear_n,
  serial_word_tx_if.slave bus
);

  // The bit counter must reach WIDTH, hence WIDTH+1 distinct values.
  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 1);
  localparam logic [7:0]       GAP_LEN  = 8'(GAP_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t             state_q,      state_d;
  logic [WIDTH-1:0]   shift_q,      shift_d;
  logic [CNT_W-1:0]   bit_cnt_q,    bit_cnt_d;
  logic [7:0]         gap_cnt_q,    gap_cnt_d;
  logic               in_ready_q,   in_ready_d;
  logic               ser_out_q,    ser_out_d;
  logic               ser_valid_q,  ser_valid_d;
  logic               frame_done_q, frame_done_d;
  logic               busy_q,       busy_d;

  // ---------------------------------------------------------------------------
  // Send-end selection. in_head/in_shifted are used on the accept edge, where
  // the first bit is presented straight from in_data while the rest of the
  // word is loaded already shifted by one. buf_head/buf_shifted serve every
  // later bit. Vacated positions fill with 0.
  // ---------------------------------------------------------------------------
  logic             in_head;
  logic             buf_head;
  logic [WIDTH-1:0] in_shifted;
  logic [WIDTH-1:0] buf_shifted;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign in_head     = bus.in_data[WIDTH-1];
      assign in_shifted  = {bus.in_data[WIDTH-2:0], 1'b0};
      assign buf_head    = shift_q[WIDTH-1];
      assign buf_shifted = {shift_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign in_head     = bus.in_data[0];
      assign in_shifted  = {1'b0, bus.in_data[WIDTH-1:1]};
      assign buf_head    = shift_q[0];
      assign buf_shifted = {1'b0, shift_q[WIDTH-1:1]};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic. ser_out/ser_valid/frame_done default to 0 so that
  // ser_out is forced low in every cycle that carries no frame bit.
  // bit_cnt counts bits already placed on ser_out in the current frame.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    in_ready_d   = in_ready_q;
    busy_d       = busy_q;
    ser_out_d    = 1'b0;
    ser_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
        bit_cnt_d  = '0;
        gap_cnt_d  = '0;
        if (bus.in_valid && in_ready_q) begin
          shift_d     = in_shifted;
          ser_out_d   = in_head;
          ser_valid_d = 1'b1;
          bit_cnt_d   = CNT_ONE;
          in_ready_d  = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (bit_cnt_q == CNT_LAST) begin
          // The last bit is on ser_out this cycle; the frame ends here.
          bit_cnt_d = '0;
          if (GAP_CYCLES == 0) begin
            state_d    = S_IDLE;
            in_ready_d = 1'b1;
            busy_d     = 1'b0;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = 8'd1;
          end
        end else begin
          ser_out_d    = buf_head;
          ser_valid_d  = 1'b1;
          shift_d      = buf_shifted;
          bit_cnt_d    = bit_cnt_q + CNT_ONE;
          // The bit being registered now is the final one of the frame.
          frame_done_d = (bit_cnt_q == CNT_PEN);
        end
      end

      S_GAP: begin
        // gap_cnt holds the number of the gap cycle currently in progress.
        if (gap_cnt_q == GAP_LEN) begin
          state_d    = S_IDLE;
          gap_cnt_d  = '0;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
        bit_cnt_d  = '0;
        gap_cnt_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Single register stage for state, datapath and every output.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      in_ready_q   <= 1'b1;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      in_ready_q   <= in_ready_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.ser_out    = ser_out_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_word_tx
//   Two serializers share clk/clear_n:
//     inst 0: WIDTH=6, GAP_CYCLES=1, MSB_FIRST=1 (feeds a 6-stage downstream
//             shift register model)
//     inst 1: WIDTH=6, GAP_CYCLES=0, MSB_FIRST=0
//   On each accepted word the reference model queues the expected bit sequence
//   and records the accept cycle; a negedge monitor pops a bit whenever the
//   DUT asserts ser_valid and checks handshake/qualifier timing from the cycle
//   distance to the last accept.
// -----------------------------------------------------------------------------
module tb_serial_word_tx;

  localparam int W  = 6;
  localparam int NI = 2;

  logic clk = 1'b0;
  logic clear_n;
  always #5 clk = ~clk;

  serial_word_tx_if #(.WIDTH(W)) bus_a ();
  serial_word_tx_if #(.WIDTH(W)) bus_b ();

  serial_word_tx #(.WIDTH(W), .GAP_CYCLES(1), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .clear_n(clear_n), .bus(bus_a.slave));
  serial_word_tx #(.WIDTH(W), .GAP_CYCLES(0), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .clear_n(clear_n), .bus(bus_b.slave));

  logic [W-1:0] drv_data  [NI];
  logic         drv_valid [NI];
  assign bus_a.in_data  = drv_data[0];
  assign bus_a.in_valid = drv_valid[0];
  assign bus_b.in_data  = drv_data[1];
  assign bus_b.in_valid = drv_valid[1];

  logic o_ready [NI];
  logic o_sout  [NI];
  logic o_svld  [NI];
  logic o_done  [NI];
  logic o_busy  [NI];
  assign o_ready[0] = bus_a.in_ready;
  assign o_sout[0]  = bus_a.ser_out;
  assign o_svld[0]  = bus_a.ser_valid;
  assign o_done[0]  = bus_a.frame_done;
  assign o_busy[0]  = bus_a.busy;
  assign o_ready[1] = bus_b.in_ready;
  assign o_sout[1]  = bus_b.ser_out;
  assign o_svld[1]  = bus_b.ser_valid;
  assign o_done[1]  = bus_b.frame_done;
  assign o_busy[1]  = bus_b.busy;

  // Downstream 6-stage register behind inst 0: ds[W-1] is q6, ds[0] is q1.
  logic [W-1:0] ds = '0;
  always @(posedge clk) ds <= {ds[W-2:0], o_sout[0]};

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int           cyc = 0;
  bit           has_acc   [NI];
  int           acc_cyc   [NI];
  int           acc_cnt   [NI];
  logic [W-1:0] last_word [NI];
  int           exp_q     [NI][$];   // bit | (last_of_frame << 1)
  int           errors = 0;
  int           checks = 0;

  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic bit msb_of(input int i);
    return (i == 0);
  endfunction

  // Ready in cycle c once the previous frame and its gap are fully over.
  function automatic bit model_ready(input int i, input int c);
    return !has_acc[i] || ((c - acc_cyc[i]) >= (W + gap_of(i) + 1));
  endfunction

  task automatic chk(input int i, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL inst%0d %s: got %0h expected %0h (cycle %0d)",
               i, name, act, exp, cyc);
    end
  endtask

  // Edge number == cycle number that the edge closes.
  always @(posedge clk) begin
    if (clear_n === 1'b1) begin
      for (int i = 0; i < NI; i++) begin
        if (drv_valid[i] === 1'b1 && model_ready(i, cyc)) begin
          has_acc[i]   = 1'b1;
          acc_cyc[i]   = cyc;
          acc_cnt[i]   = acc_cnt[i] + 1;
          last_word[i] = drv_data[i];
          for (int n = 0; n < W; n++) begin
            int pos;
            pos = msb_of(i) ? (W - 1 - n) : n;
            exp_q[i].push_back(int'(drv_data[i][pos]) + ((n == W - 1) ? 2 : 0));
          end
          $display("tb: inst%0d accepts word %02h at edge %0d", i, drv_data[i], cyc);
        end
      end
    end
    cyc++;
  end

  always @(negedge clear_n) begin
    for (int i = 0; i < NI; i++) begin
      has_acc[i] = 1'b0;
      exp_q[i].delete();
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (clear_n === 1'b1) begin
      for (int i = 0; i < NI; i++) begin
        int d;
        int head;
        bit e_valid;
        bit e_busy;
        bit e_done;
        d       = has_acc[i] ? (cyc - acc_cyc[i]) : -1;
        e_valid = (d >= 1) && (d <= W);
        e_busy  = (d >= 1) && (d <= W + gap_of(i));
        e_done  = (d == W);
        chk(i, "in_ready",   32'(o_ready[i]), 32'(!e_busy));
        chk(i, "busy",       32'(o_busy[i]),  32'(e_busy));
        chk(i, "ser_valid",  32'(o_svld[i]),  32'(e_valid));
        chk(i, "frame_done", 32'(o_done[i]),  32'(e_done));
        if (o_svld[i] === 1'b1) begin
          chk(i, "bit_expected", 32'(exp_q[i].size() > 0), 32'd1);
          if (exp_q[i].size() > 0) begin
            head = exp_q[i].pop_front();
            chk(i, "ser_out",        32'(o_sout[i]), 32'(head & 1));
            chk(i, "last_bit_done",  32'(o_done[i]), 32'((head >> 1) & 1));
          end
        end else begin
          chk(i, "ser_out_idle", 32'(o_sout[i]), 32'd0);
        end
        if (i == 0 && d == W + 1)
          chk(i, "downstream_q6_q1", 32'(ds), 32'(last_word[0]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_idle();
    int n = 0;
    while (!(model_ready(0, cyc) && model_ready(1, cyc)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(0, "idle_timeout", 32'(n < 100), 32'd1);
  endtask

  task automatic wait_acc(input int i, input int target);
    int n = 0;
    while (acc_cnt[i] < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(i, "accept_timeout", 32'(acc_cnt[i] >= target), 32'd1);
  endtask

  task automatic set_both(input logic v, input logic [W-1:0] w);
    for (int i = 0; i < NI; i++) begin
      drv_valid[i] = v;
      drv_data[i]  = w;
    end
  endtask

  task automatic pulse(input logic [W-1:0] w);
    @(negedge clk);
    set_both(1'b1, w);
    @(negedge clk);
    drv_valid[0] = 1'b0;
    drv_valid[1] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk(i, {tag, "_in_ready"},   32'(o_ready[i]), 32'd1);
      chk(i, {tag, "_ser_out"},    32'(o_sout[i]),  32'd0);
      chk(i, {tag, "_ser_valid"},  32'(o_svld[i]),  32'd0);
      chk(i, {tag, "_frame_done"}, 32'(o_done[i]),  32'd0);
      chk(i, {tag, "_busy"},       32'(o_busy[i]),  32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int start;
    for (int i = 0; i < NI; i++) begin
      has_acc[i]   = 1'b0;
      acc_cyc[i]   = 0;
      acc_cnt[i]   = 0;
      last_word[i] = '0;
    end
    set_both(1'b0, '0);
    clear_n = 1'b1;
    #1 clear_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    clear_n = 1'b1;

    // Single word, one-cycle valid.
    wait_idle();
    pulse(6'b101101);
    wait_idle();

    // Valid held across two words.
    @(negedge clk);
    start = acc_cnt[0];
    set_both(1'b1, 6'h2A);
    wait_acc(0, start + 1);
    drv_data[0] = 6'h15;
    drv_data[1] = 6'h15;
    wait_acc(0, start + 2);
    set_both(1'b0, '0);
    wait_idle();

    // in_data changes during the shift of an all-zero word.
    @(negedge clk);
    start = acc_cnt[0];
    set_both(1'b1, 6'h00);
    @(negedge clk);
    drv_data[0] = 6'h3F;
    drv_data[1] = 6'h3F;
    wait_acc(0, start + 2);
    set_both(1'b0, '0);
    wait_idle();

    // Asynchronous clear during the third bit.
    pulse(6'b101101);
    repeat (2) @(negedge clk);
    #2 clear_n = 1'b0;
    #1 check_reset_outputs("midframe_clear");
    @(negedge clk);
    clear_n = 1'b1;
    wait_idle();

    // Single set bit, then back-to-back words.
    pulse(6'b000001);
    wait_idle();
    @(negedge clk);
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NI; i++) begin
        drv_valid[i] = 1'b1;
        drv_data[i]  = W'($urandom);
      end
      @(negedge clk);
    end
    set_both(1'b0, '0);
    wait_idle();

    // Random traffic with independent producers.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        drv_valid[i] = ($urandom_range(0, 3) != 0);
        drv_data[i]  = W'($urandom);
      end
    end
    @(negedge clk);
    set_both(1'b0, '0);
    wait_idle();
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk(i, "drained_queue", 32'(exp_q[i].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
